// File: rtl/main_if.sv
// Button-side bus of the debouncer: the raw pin level and the
// debounced output level.
`timescale 1ns/1ps

interface main_if;
    logic BTNC;
    logic stableSignal;

    modport master (
        output BTNC,
        input  stableSignal
    );

    modport slave (
        input  BTNC,
        output stableSignal
    );
endinterface

// File: rtl/main.sv
// Counter-based push-button debouncer for the 100 MHz domain.
// Define DEBOUNCE_SYNC_EN to insert a two-flop input synchronizer.
`timescale 1ns/1ps

module main #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic  CLK100MHZ,
    input  logic  BTNU,
    main_if.slave bus
);
    localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

    logic         sample;
    logic         stable;
    logic [W-1:0] count;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge CLK100MHZ or negedge BTNU) begin
        if (!BTNU) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], bus.BTNC};
        end
    end

    assign sample = sync[1];
`else
    assign sample = bus.BTNC;
`endif

    // Any agreeing sample discards the run; no partial credit.
    always_ff @(posedge CLK100MHZ or negedge BTNU) begin
        if (!BTNU) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sample == stable) begin
            count <= '0;
        end else if (count == LAST) begin
            stable <= sample;
            count  <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign bus.stableSignal = stable;
endmodule

// File: tb/tb_main.sv
// Self-checking bench for the debouncer: window-based reference
// model compared every cycle, plus directed latency checks.
`timescale 1ns/1ps

module tb_main;
    localparam int N = 1000;
`ifdef DEBOUNCE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk;
    logic rst_n;

    main_if bus ();
    main_if bus1 ();

    main #(.DEBOUNCE_CYCLES(N)) dut (
        .CLK100MHZ(clk),
        .BTNU(rst_n),
        .bus(bus.slave)
    );

    main #(.DEBOUNCE_CYCLES(1)) dut1 (
        .CLK100MHZ(clk),
        .BTNU(rst_n),
        .bus(bus1.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Output flips once the last N samples all disagree with it.
    bit win[$];
    bit m_out;
    bit d0, d1;

    always @(posedge clk or negedge rst_n) begin
        bit s;
        bit all;
        if (!rst_n) begin
            m_out = 1'b0;
            win.delete();
            d0 = 1'b0;
            d1 = 1'b0;
        end else begin
`ifdef DEBOUNCE_SYNC_EN
            s  = d1;
            d1 = d0;
            d0 = bus.BTNC;
`else
            s = bus.BTNC;
`endif
            win.push_back(s);
            if (win.size() > N) void'(win.pop_front());
            if (win.size() == N) begin
                all = 1'b1;
                foreach (win[i]) if (win[i] == m_out) all = 1'b0;
                if (all) m_out = ~m_out;
            end
        end
    end

    always @(negedge clk) begin
        check("model", int'(bus.stableSignal), int'(m_out));
    end

    task automatic wait_out(input bit sel, input bit val,
                            input int maxe, output int edges);
        logic o;
        edges = -1;
        for (int e = 1; e <= maxe; e++) begin
            @(posedge clk);
            #1;
            o = sel ? bus1.stableSignal : bus.stableSignal;
            if (o == val) begin
                edges = e;
                break;
            end
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst_n     = 1'b0;
        bus.BTNC  = 1'b0;
        bus1.BTNC = 1'b0;

        // 1: reset then idle low
        #3;
        check("rst_out", int'(bus.stableSignal), 0);
        check("rst_cnt", int'(dut.count), 0);
        #7;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_out", int'(bus.stableSignal), 0);
        check("idle_cnt", int'(dut.count), 0);

        // DEBOUNCE_CYCLES = 1 instance
        bus1.BTNC = 1'b1;
        wait_out(1'b1, 1'b1, 10, e);
        check("n1_rise", e, LAT + 1);
        @(negedge clk);
        bus1.BTNC = 1'b0;
        wait_out(1'b1, 1'b0, 10, e);
        check("n1_fall", e, LAT + 1);

        // 2: bouncy press, then held high
        @(negedge clk);
        #1.5;
        repeat (8) begin
            bus.BTNC = ~bus.BTNC;
            #1;
        end
        bus.BTNC = 1'b1;
        wait_out(1'b0, 1'b1, N + 20, e);
        check("s2_rise", e, N + LAT);
        repeat (50) @(negedge clk);
        check("s2_hold", int'(bus.stableSignal), 1);

        // 3: release
        bus.BTNC = 1'b0;
        wait_out(1'b0, 1'b0, N + 20, e);
        check("s3_fall", e, N + LAT);

        // 4: single-cycle dip restarts qualification
        @(negedge clk);
        bus.BTNC = 1'b1;
        repeat (500) @(negedge clk);
        check("s4_pre", int'(bus.stableSignal), 0);
        bus.BTNC = 1'b0;
        @(negedge clk);
        bus.BTNC = 1'b1;
        wait_out(1'b0, 1'b1, N + 20, e);
        check("s4_rise", e, N + LAT);

        // 6: async reset between edges while high
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #0.5;
        check("s6_out", int'(bus.stableSignal), 0);
        check("s6_cnt", int'(dut.count), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5: reset mid-count, then full requalification
        repeat (600) @(negedge clk);
        check("s5_pre", int'(bus.stableSignal), 0);
        check("s5_cnt_pre", int'(dut.count), 600 - LAT);
        #2;
        rst_n = 1'b0;
        #1;
        check("s5_out", int'(bus.stableSignal), 0);
        check("s5_cnt", int'(dut.count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_out(1'b0, 1'b1, N + 20, e);
        check("s5_rise", e, N + LAT);
        check("s5_model", int'(m_out), 1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
